// File: rtl/icache_sa.sv
// Set-associative instruction cache between the fetch stage and the read bus.
// Flop-based tag/valid/data arrays, per-set LRU replacement (two ways),
// critical-word forwarding on refill, whole-cache flush and hit/miss counters.
module icache_sa #(
  parameter int unsigned WAYS      = 2,
  parameter int unsigned SETS      = 64,
  parameter int unsigned BLK_WORDS = 4
) (
  input  logic                    cpu_clk,
  input  logic                    cpu_rstn,
  input  logic                    inst_rreq,
  input  logic [31:0]             inst_addr,
  input  logic                    flush,
  output logic                    inst_valid,
  output logic [31:0]             inst_out,
  output logic                    busy,
  input  logic                    mem_rrdy,
  output logic [3:0]              mem_ren,
  output logic [31:0]             mem_raddr,
  input  logic                    mem_rvalid,
  input  logic [BLK_WORDS*32-1:0] mem_rdata,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int unsigned OB = $clog2(BLK_WORDS) + 2;
  localparam int unsigned IB = $clog2(SETS);
  localparam int unsigned TW = 32 - OB - IB;
  localparam int unsigned WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StLookup  = 2'd1;
  localparam logic [1:0] StMissReq = 2'd2;
  localparam logic [1:0] StRefill  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:2] req_addr_q;
  logic        flush_pend_q;

  logic        inst_valid_q;
  logic [31:0] inst_out_q;
  logic [3:0]  mem_ren_q;
  logic [31:0] mem_raddr_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Storage arrays; only valid and LRU bits are reset.
  logic [SETS-1:0]        valid_q [WAYS];
  logic [SETS-1:0]        lru_q;
  logic [TW-1:0]          tag_q   [WAYS][SETS];
  logic [BLK_WORDS*32-1:0] data_q [WAYS][SETS];

  logic [OB-3:0] req_off;
  logic [IB-1:0] req_idx;
  logic [TW-1:0] req_tag;

  logic          hit;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] victim;
  logic          victim_found;

  logic do_flush;
  logic accept;
  logic lookup_hit;
  logic lookup_miss;
  logic issue;
  logic refill_done;

  // Byte-lane bits of the fetch address carry no information.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^inst_addr[1:0];

  assign req_off = req_addr_q[OB-1:2];
  assign req_idx = req_addr_q[OB+IB-1:OB];
  assign req_tag = req_addr_q[31:OB+IB];

  function automatic logic [31:0] pick_word(input logic [BLK_WORDS*32-1:0] blk,
                                            input logic [OB-3:0]           off);
    return blk[32*off +: 32];
  endfunction

  // A pending or fresh flush takes priority over a new request in IDLE.
  assign do_flush    = (state_q == StIdle) && (flush_pend_q || flush);
  assign accept      = (state_q == StIdle) && !do_flush && inst_rreq;
  assign lookup_hit  = (state_q == StLookup) && hit;
  assign lookup_miss = (state_q == StLookup) && !hit;
  assign issue       = (state_q == StMissReq) && mem_rrdy;
  assign refill_done = (state_q == StRefill) && mem_rvalid;

  // Tag compare across all valid ways of the requested set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // Victim: lowest invalid way, else the LRU way.
  always_comb begin
    victim       = '0;
    victim_found = 1'b0;
    if (WAYS > 1) begin
      victim = WW'(lru_q[req_idx]);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[w][req_idx]) begin
        victim       = WW'(w);
        victim_found = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept)      state_d = StLookup;
      StLookup:  state_d = hit ? StIdle : StMissReq;
      StMissReq: if (mem_rrdy)    state_d = StRefill;
      StRefill:  if (mem_rvalid)  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request address latch.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      req_addr_q <= '0;
    end else if (accept) begin
      req_addr_q <= inst_addr[31:2];
    end
  end

  // Deferred flush: remembered while busy, consumed in the next IDLE cycle.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      flush_pend_q <= 1'b0;
    end else if (state_q != StIdle) begin
      if (flush) begin
        flush_pend_q <= 1'b1;
      end
    end else begin
      flush_pend_q <= 1'b0;
    end
  end

  // Valid and LRU bits; LRU names the way to evict next.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
      end
      lru_q <= '0;
    end else if (do_flush) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
      end
      lru_q <= '0;
    end else begin
      if (refill_done) begin
        valid_q[victim][req_idx] <= 1'b1;
        if (WAYS > 1) begin
          lru_q[req_idx] <= ~victim[0];
        end
      end
      if (lookup_hit && (WAYS > 1)) begin
        lru_q[req_idx] <= ~hit_way[0];
      end
    end
  end

  // Tag and data arrays are written only on refill completion.
  always_ff @(posedge cpu_clk) begin
    if (refill_done) begin
      tag_q[victim][req_idx]  <= req_tag;
      data_q[victim][req_idx] <= mem_rdata;
    end
  end

  // Instruction return and bus request outputs.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      mem_ren_q    <= 4'h0;
      mem_raddr_q  <= '0;
    end else begin
      inst_valid_q <= lookup_hit || refill_done;
      if (lookup_hit) begin
        inst_out_q <= pick_word(data_q[hit_way][req_idx], req_off);
      end else if (refill_done) begin
        // Critical word straight from the bus, no second lookup.
        inst_out_q <= pick_word(mem_rdata, req_off);
      end
      mem_ren_q <= issue ? 4'hF : 4'h0;
      if (issue) begin
        mem_raddr_q <= {req_addr_q[31:OB], {OB{1'b0}}};
      end
    end
  end

  // Hit/miss counters; unaffected by flush, wrap naturally.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (lookup_miss) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign busy       = (state_q != StIdle) || flush_pend_q;
  assign mem_ren    = mem_ren_q;
  assign mem_raddr  = mem_raddr_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache between the CPU fetch stage and the read bus. It replaces the fixed 64-set direct-mapped ICache with configurable ways, sets and block length, per-set LRU replacement, critical-word forwarding on refill, a whole-cache flush input and hit/miss counters. Tag, valid and data arrays are flop-based inside the block, with no memory IP.

## Interface
- `WAYS`, 2: associativity, 1 or 2.
- `SETS`, 64: number of sets, power of two, ≥ 2.
- `BLK_WORDS`, 4: 32-bit words per block, power of two, 2 to 8.
- `cpu_clk` in 1: the only clock. All logic is on the rising edge.
- `cpu_rstn` in 1: asynchronous, active-low reset.
- `inst_rreq` in 1: fetch request. Sampled only in IDLE.
- `inst_addr` in 32: fetch address. Bits [1:0] are ignored.
- `flush` in 1: invalidate-all request, one-cycle pulse.
- `inst_valid` out 1: instruction valid, one-cycle pulse.
- `inst_out` out 32: instruction word. Valid only while `inst_valid` = 1.
- `busy` out 1: high in any state other than IDLE, or while a flush is pending.
- `mem_rrdy` in 1: bus ready to accept a read.
- `mem_ren` out 4: read enable. Driven to 4'hF for exactly one cycle per refill.
- `mem_raddr` out 32: block-aligned refill address.
- `mem_rvalid` in 1: refill data valid.
- `mem_rdata` in BLK_WORDS*32: refill block. Word i occupies bits [32i+31:32i].
- `hit_cnt` out 32: number of hits. Wraps at 2^32.
- `miss_cnt` out 32: number of misses. Wraps at 2^32.

## Operation
- **Address split**
  - offset = `inst_addr`[OB-1:2], where OB = log2(BLK_WORDS) + 2.
  - index = next log2(SETS) bits.
  - tag = remaining upper bits (full width, no address-range limit).
- **Reset** (`cpu_rstn` low, asynchronous) forces:
  - state IDLE;
  - all valid bits 0;
  - all LRU bits 0;
  - `inst_valid` 0, `inst_out` 0;
  - `mem_ren` 0, `mem_raddr` 32'h0;
  - `hit_cnt` 0, `miss_cnt` 0;
  - pending-flush flag 0.
  - Data and tag arrays need no reset.
- **State machine**
  - IDLE:
    - If a flush is pending, or `flush` = 1: clear all valid bits and LRU bits this cycle, then stay in IDLE. A request presented in the same cycle is not accepted.
    - Else if `inst_rreq` = 1: latch the address into req_addr and go to LOOKUP.
  - LOOKUP: compare req_addr's tag against every valid way of its set.
    - Hit:
      - `inst_valid` <= 1;
      - `inst_out` <= the hit way's word at offset;
      - LRU[set] <= the way not hit (WAYS = 2 only);
      - `hit_cnt` += 1;
      - go to IDLE.
    - Miss: `miss_cnt` += 1; go to MISS_REQ.
  - MISS_REQ: when `mem_rrdy` = 1:
    - `mem_ren` <= 4'hF for one cycle;
    - `mem_raddr` <= {req_addr[31:OB], OB'b0};
    - go to REFILL.
    - Otherwise wait, with `mem_ren` = 0.
  - REFILL: when `mem_rvalid` = 1:
    - write the victim way with data, tag and valid = 1;
    - LRU[set] <= the other way;
    - `inst_valid` <= 1;
    - `inst_out` <= `mem_rdata` word at offset (forwarded, no second lookup);
    - go to IDLE.
- **Victim selection**
  - The lowest-numbered invalid way.
  - If all ways are valid: the LRU way.
  - WAYS = 1: always way 0, and LRU is unused.
- **Flush while busy**: a `flush` pulse outside IDLE sets the pending flag.
  - An in-flight lookup or refill completes and delivers its instruction normally.
  - The invalidation then happens in the next IDLE cycle.
- `inst_rreq` outside IDLE is ignored. The CPU re-requests after `inst_valid`.
- `mem_rvalid` outside REFILL is ignored.

## Timing
- **Hit latency**: `inst_rreq` sampled at edge E0 → `inst_valid` high during the cycle after E1. That is 2 cycles from request to data.
- **Miss latency**: 2 + (MISS_REQ wait) + 1 + (memory latency) cycles.
  - `inst_valid` rises on the edge after the `mem_rvalid` sample.
- `inst_valid` is high for exactly one cycle. Its earliest next assertion is 2 cycles later.
- `mem_ren` is never high for two consecutive cycles, and is never high outside the MISS_REQ→REFILL transition.
- `mem_raddr` holds its value until the next refill.
- **Reset mid-refill**: the in-flight block is abandoned and nothing is written. The bus side shares the same reset.
- **Simultaneous events**: counter increments and flush can coincide. A flush does not clear the counters.

## Test plan
1. **Cold miss, then hit**
   - Stimulus: reset; request 0x0000_1004; `mem_rrdy` = 1; `mem_rvalid` 3 cycles after `mem_ren` with block {0xD,0xC,0xB,0xA}.
   - Required: `mem_raddr` = 0x0000_1000; `inst_out` = 0xB; `miss_cnt` = 1.
   - Then re-request 0x0000_1008 → `inst_out` = 0xC two cycles after the request; `hit_cnt` = 1.
2. **2-way LRU conflict** (WAYS = 2, SETS = 64, BLK_WORDS = 4)
   - Stimulus: fill 0x0000_0000 and 0x0000_0400 (same set); hit 0x0000_0000; then request 0x0000_0800.
   - Required: the 0x400 line is evicted. A later request to 0x0000_0000 hits; a later request to 0x0000_0400 misses.
3. **Bus back-pressure**
   - Stimulus: miss with `mem_rrdy` held 0 for 5 cycles.
   - Required: `mem_ren` stays 0 and `busy` = 1 throughout; `mem_ren` = 4'hF for exactly 1 cycle after `mem_rrdy` rises.
4. **Flush during refill**
   - Stimulus: pulse `flush` while in REFILL.
   - Required: the refill instruction is still delivered. The next request to the same address misses; `miss_cnt` increments.
5. **Reset mid-refill**
   - Stimulus: drop `cpu_rstn` in REFILL.
   - Required: all outputs return to their reset values immediately (asynchronously). A request after release misses.
6. **Configuration sweep**
   - Stimulus: WAYS = 1, BLK_WORDS = 8, SETS = 16, random address stream against a reference model.
   - Required: every `inst_out` matches the memory image; `hit_cnt` + `miss_cnt` equals the number of requests.
